serial_add_sched: RTL and testbench

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

---
 rtl/serial_add_sched.sv | 169 ++++++++++++++++
 tb/tb_serial_add_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sched.sv
// Two requesters share one bit-serial adder. A round-robin arbiter picks the requester,
// and the adder then processes one bit per cycle, LSB first.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

  assign co = c1 | c2;
endmodule

module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic             last_id;
  logic             cur_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             finish;
  logic             grant_id;
  logic [1:0]       gnt_next;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // Round-robin: a lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant_id = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_id;
      default: grant_id = 1'b0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        if (cnt == LAST_BIT) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign gnt_next = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign busy     = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake and result registers, visible to the requesters.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= 2'b00;
      done    <= 1'b0;
      done_id <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      last_id <= 1'b1;
    end else begin
      gnt  <= gnt_next;
      done <= finish;
      if (accept) last_id <= grant_id;
      if (finish) begin
        sum     <= {fa_s, res[WIDTH-1:1]};
        cout    <= fa_c;
        done_id <= cur_id;
      end
    end
  end

  // NOTE: the shift registers are cleared on reset too, so an aborted operation leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cur_id <= 1'b0;
    end else if (accept) begin
      op_a   <= grant_id ? a1 : a0;
      op_b   <= grant_id ? b1 : b0;
      carry  <= 1'b0;
      cnt    <= '0;
      cur_id <= grant_id;
    end else if (state == ADD) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      res   <= {fa_s, res[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched: directed scenarios plus randomized operations,
// checked against an arithmetic and round-robin reference model.

module tb_serial_add_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]   gnt;
  logic         busy, done, done_id, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic m_last = 1'b1;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One complete transaction starting from IDLE. Model: round-robin pick and (a+b) mod 2^W.
  task automatic run_op(input logic [1:0] r, input logic [W-1:0] ia0, input logic [W-1:0] ib0,
                        input logic [W-1:0] ia1, input logic [W-1:0] ib1,
                        input logic [W-1:0] na0, input int pulse_at, input string tag);
    logic       id;
    logic [W:0] e;
    int         lat;
    int         extra_gnt;
    int         dones;
    id = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : ~m_last;
    m_last = id;
    e = id ? ({1'b0, ia1} + {1'b0, ib1}) : ({1'b0, ia0} + {1'b0, ib0});
    req = r; a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1;
    tick();
    check({tag, " gnt"}, {30'd0, gnt}, id ? 32'd2 : 32'd1);
    check({tag, " busy_at_gnt"}, {31'd0, busy}, 32'd1);
    a0 = na0; b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    lat = -1; extra_gnt = 0; dones = 0;
    for (int i = 1; i <= 20 && dones == 0; i++) begin
      req = (i == pulse_at) ? 2'b10 : 2'b00;
      tick();
      if (gnt != 2'b00) extra_gnt++;
      if (done) begin
        dones++;
        lat = i;
      end
    end
    req = 2'b00;
    check({tag, " latency"}, lat, W);
    check({tag, " sum"}, {24'd0, sum}, {24'd0, e[W-1:0]});
    check({tag, " cout"}, {31'd0, cout}, {31'd0, e[W]});
    check({tag, " done_id"}, {31'd0, done_id}, {31'd0, id});
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gnt != 2'b00) extra_gnt++;
      if (done) dones++;
      if (i == 0) check({tag, " idle_after"}, {31'd0, busy}, 32'd0);
    end
    check({tag, " extra_gnt"}, extra_gnt, 0);
    check({tag, " done_count"}, dones, 1);
  endtask

  initial begin
    int gq_c[$];
    logic gq_id[$];
    int dq_c[$];
    logic dq_id[$];
    logic [W-1:0] dq_sum[$];
    int quiet_done;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst gnt", {30'd0, gnt}, 0);
    check("rst busy", {31'd0, busy}, 0);
    check("rst done", {31'd0, done}, 0);
    check("rst done_id", {31'd0, done_id}, 0);
    check("rst sum", {24'd0, sum}, 0);
    check("rst cout", {31'd0, cout}, 0);

    run_op(2'b01, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'h5A, 0, "r0_5a_3c");
    run_op(2'b10, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 0, "r1_ff_01");

    // Both requesters held continuously from reset
    rst = 1'b1; req = 2'b11;
    a0 = 8'h21; b0 = 8'h42; a1 = 8'h80; b1 = 8'h90;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (gnt != 2'b00) begin
        gq_c.push_back(c);
        gq_id.push_back(gnt[1]);
        if (gnt == 2'b11) check("hold gnt_onehot", {30'd0, gnt}, 32'd1);
        if (done) check("hold gnt_and_done", {31'd0, done}, 0);
      end
      if (done) begin
        dq_c.push_back(c);
        dq_id.push_back(done_id);
        dq_sum.push_back(sum);
      end
    end
    req = 2'b00;
    check("hold grant_count_ge4", (gq_c.size() >= 4) ? 1 : 0, 1);
    check("hold done_count_ge4", (dq_c.size() >= 4) ? 1 : 0, 1);
    if (gq_c.size() >= 4 && dq_c.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("hold grant%0d_id", k), {31'd0, gq_id[k]}, k % 2);
        if (k > 0) check($sformatf("hold grant%0d_spacing", k), gq_c[k] - gq_c[k-1], W + 2);
        check($sformatf("hold done%0d_id", k), {31'd0, dq_id[k]}, k % 2);
        check($sformatf("hold done%0d_latency", k), dq_c[k] - gq_c[k], W);
        check($sformatf("hold done%0d_sum", k), {24'd0, dq_sum[k]},
              (k % 2) ? 32'h10 : 32'h63);
      end
    end
    for (int i = 0; i < 12; i++) tick();
    m_last = (gq_id.size() > 0) ? gq_id[gq_id.size()-1] : 1'b1;

    // Reset during the 4th ADD cycle aborts the operation
    req = 2'b01; a0 = 8'h12; b0 = 8'h34;
    tick();
    req = 2'b00;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 1'b1;
    check("abort busy", {31'd0, busy}, 0);
    check("abort done", {31'd0, done}, 0);
    check("abort sum", {24'd0, sum}, 0);
    check("abort cout", {31'd0, cout}, 0);
    quiet_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) quiet_done++;
    end
    check("abort no_done", quiet_done, 0);
    run_op(2'b01, 8'hC3, 8'h4E, 8'h00, 8'h00, 8'hC3, 0, "after_abort");

    // Operand change after the grant has no effect
    run_op(2'b01, 8'h10, 8'h01, 8'h00, 8'h00, 8'hEE, 0, "late_a0");

    // Short req[1] pulse while busy is ignored
    run_op(2'b01, 8'h77, 8'h99, 8'hAA, 8'h55, 8'h77, 3, "pulse_ignored");

    // Randomized transactions
    for (int n = 0; n < 16; n++) begin
      logic [1:0] r;
      logic [W-1:0] ra0;
      r = 2'($urandom_range(1, 3));
      ra0 = W'($urandom);
      run_op(r, ra0, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0,
             $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
